// File: rtl/mono_sample_to_packet_converter.sv
// Repacks mono samples into two-beat stereo AXI4-Stream packets (left, right+TLAST).
// Optional saturating drop counter enabled by defining MONO_PKT_DROP_CNT_EN.
module mono_sample_to_packet_converter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic                  mono_sample_valid,
  input  logic [DATA_WIDTH-1:0] mono_sample,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  overflow
`ifdef MONO_PKT_DROP_CNT_EN
  ,
  output logic [15:0]           dropped_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            count;

  logic                  pop_c;
  logic                  write_c;
  logic                  drop_c;
  logic [DATA_WIDTH-1:0] tdata_next;
  logic                  tvalid_next;
  logic                  tlast_next;

  // Buffer write/pop qualification; a full buffer still accepts on a pop cycle.
  always_comb begin
    pop_c   = (state == S_RIGHT) && M_AXIS_TREADY;
    write_c = mono_sample_valid && ((count != 2'd2) || pop_c);
    drop_c  = mono_sample_valid && !write_c;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state;
    tdata_next  = M_AXIS_TDATA;
    tvalid_next = M_AXIS_TVALID;
    tlast_next  = M_AXIS_TLAST;
    case (state)
      S_IDLE: begin
        if (write_c) begin
          state_next  = S_LEFT;
          tdata_next  = mono_sample;
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
        end
      end
      S_LEFT: begin
        if (M_AXIS_TREADY) begin
          state_next = S_RIGHT;
          tlast_next = 1'b1;
        end
      end
      S_RIGHT: begin
        if (M_AXIS_TREADY) begin
          if (count == 2'd2) begin
            state_next = S_LEFT;
            tdata_next = mem[~head];
            tlast_next = 1'b0;
          end else if (write_c) begin
            state_next = S_LEFT;
            tdata_next = mono_sample;
            tlast_next = 1'b0;
          end else begin
            state_next  = S_IDLE;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
          end
        end
      end
      default: begin
        state_next  = S_IDLE;
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
      end
    endcase
  end

  // State, outputs and buffer bookkeeping.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state         <= S_IDLE;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      overflow      <= 1'b0;
      head          <= 1'b0;
      tail          <= 1'b0;
      count         <= 2'd0;
    end else begin
      state         <= state_next;
      M_AXIS_TDATA  <= tdata_next;
      M_AXIS_TVALID <= tvalid_next;
      M_AXIS_TLAST  <= tlast_next;
      overflow      <= drop_c;
      if (write_c) tail <= ~tail;
      if (pop_c)   head <= ~head;
      count <= count + 2'(write_c) - 2'(pop_c);
    end
  end

  // Sample storage carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (write_c) mem[tail] <= mono_sample;
  end

`ifdef MONO_PKT_DROP_CNT_EN
  // Saturating count of discarded samples.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      dropped_count <= 16'd0;
    end else if (drop_c && (dropped_count != 16'hFFFF)) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mono_sample_to_packet_converter.sv
// Self-checking bench for mono_sample_to_packet_converter: directed scenarios plus
// randomized backpressure, checked every cycle against a queue-based reference model.
module tb_mono_sample_to_packet_converter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mono_sample_valid = 1'b0;
  logic [31:0] mono_sample = '0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b0;
  logic        overflow;
`ifdef MONO_PKT_DROP_CNT_EN
  logic [15:0] dropped_count;
`endif

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;

  // Reference model: queue of buffered samples, head is on the wire; beat_right selects the beat.
  logic [31:0] q[$];
  bit          beat_right = 1'b0;
  bit          exp_ovf = 1'b0;
  int          exp_drops = 0;

  always #5 clk = ~clk;

  mono_sample_to_packet_converter #(.DATA_WIDTH(32)) dut (
    .M_AXIS_ACLK      (clk),
    .M_AXIS_ARESETN   (rstn),
    .mono_sample_valid(mono_sample_valid),
    .mono_sample      (mono_sample),
    .M_AXIS_TDATA     (tdata),
    .M_AXIS_TVALID    (tvalid),
    .M_AXIS_TLAST     (tlast),
    .M_AXIS_TREADY    (tready),
    .overflow         (overflow)
`ifdef MONO_PKT_DROP_CNT_EN
    ,
    .dropped_count    (dropped_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [31:0] s, input bit rdy, input bit rst_ok);
    int  sz;
    bit  hs;
    bit  pop;
    exp_ovf = 1'b0;
    if (!rst_ok) begin
      q.delete();
      beat_right = 1'b0;
      exp_drops  = 0;
    end else begin
      sz  = q.size();
      hs  = (sz > 0) && rdy;
      pop = hs && beat_right;
      if (hs) begin
        if (beat_right) begin
          void'(q.pop_front());
          beat_right = 1'b0;
        end else begin
          beat_right = 1'b1;
        end
      end
      if (v) begin
        if ((sz < 2) || pop) begin
          q.push_back(s);
        end else begin
          exp_ovf = 1'b1;
          if (exp_drops < 65535) exp_drops++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("tdata", tdata, q[0]);
      chk("tlast", 32'(tlast), 32'(beat_right));
    end
    if (!rstn) begin
      chk("rst_tdata", tdata, 32'h0);
      chk("rst_tlast", 32'(tlast), 32'h0);
    end
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (overflow === 1'b1) ovf_pulses++;
`ifdef MONO_PKT_DROP_CNT_EN
    chk("dropped_count", 32'(dropped_count), 32'(exp_drops));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input bit v, input logic [31:0] s, input bit rdy);
    mono_sample_valid = v;
    mono_sample       = s;
    tready            = rdy;
    @(posedge clk);
    model_edge(v, s, rdy, rstn);
    #1;
    compare();
    mono_sample_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    rstn = 1'b1;
    step(1'b0, 32'h0, 1'b1);

    // Single sample
    step(1'b1, 32'h00AB_CDEF, 1'b1);
    chk("single_left_data", tdata, 32'h00AB_CDEF);
    chk("single_left_last", 32'(tlast), 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("single_right_last", 32'(tlast), 32'h1);
    step(1'b0, 32'h0, 1'b1);
    chk("single_idle", 32'(tvalid), 32'h0);
    step(1'b0, 32'h0, 1'b1);

    // Back-to-back packets
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 32'(i), 1'b1);
      step(1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

    // Backpressure and overflow
    ovf_pulses = 0;
    step(1'b1, 32'hA, 1'b0);
    step(1'b1, 32'hB, 1'b0);
    step(1'b1, 32'hC, 1'b0);
    step(1'b1, 32'hD, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    chk("bp_stall_data", tdata, 32'hA);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    chk("bp_ovf_pulses", 32'(ovf_pulses), 32'd2);
`ifdef MONO_PKT_DROP_CNT_EN
    chk("bp_dropped_count", 32'(dropped_count), 32'd2);
`endif

    // Simultaneous pop and write on a full buffer
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h33, 1'b1);
    chk("simul_no_ovf", 32'(overflow), 32'h0);
    chk("simul_next_head", tdata, 32'h22);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Reset in the middle of a packet
    step(1'b1, 32'h77, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_mid_right", 32'(tlast), 32'h1);
    rstn = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk("rst_mid_tvalid", 32'(tvalid), 32'h0);
    rstn = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h55, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Random TREADY at 40% duty, one sample per 4 cycles
    for (int n = 0; n < 500; n++) begin
      step(1'b1, $urandom, ($urandom_range(0, 99) < 40));
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, ($urandom_range(0, 99) < 40));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    chk("rand_drained", 32'(tvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
